// File: rtl/systolic_array_ws_if.sv
// rtl/systolic_array_ws_if.sv - weight, activation and result handshake bundle for systolic_array_ws
interface systolic_array_ws_if #(
    parameter int DATA_W = 8,
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int ACC_W  = 2 * DATA_W
);
    logic                   w_valid;
    logic                   w_ready;
    logic [COLS*DATA_W-1:0] w_data;
    logic                   a_valid;
    logic                   a_ready;
    logic [ROWS*DATA_W-1:0] a_data;
    logic                   o_valid;
    logic                   o_ready;
    logic [COLS*ACC_W-1:0]  o_data;
    logic                   busy;

    modport slave (
        input  w_valid, w_data, a_valid, a_data, o_ready,
        output w_ready, a_ready, o_valid, o_data, busy
    );

    modport master (
        output w_valid, w_data, a_valid, a_data, o_ready,
        input  w_ready, a_ready, o_valid, o_data, busy
    );
endinterface

// File: rtl/systolic_array_ws.sv
// rtl/systolic_array_ws.sv - weight-stationary ROWSxCOLS systolic MAC array; SYSTOLIC_SAT_EN selects saturating accumulation
module systolic_array_ws #(
    parameter int DATA_W = 8,
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int ACC_W  = 2 * DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    systolic_array_ws_if.slave bus
);
    // Pipeline depth from accept to o_valid; also the most vectors that can be in flight.
    localparam int DEPTH = ROWS + COLS;
    localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int INF_W = $clog2(DEPTH + 1);

`ifdef SYSTOLIC_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        S_EMPTY,
        S_LOAD,
        S_RUN
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [CNT_W-1:0]         r_wcnt;
    logic [INF_W-1:0]         r_inflight;
    logic                     w_stall;
    logic                     w_w_ready;
    logic                     w_a_ready;
    logic                     w_w_fire;
    logic                     w_a_fire;
    logic                     w_o_fire;
    logic                     w_last_beat;

    // Stationary weights; row 0 is the top of the array.
    logic signed [DATA_W-1:0] r_w [ROWS][COLS];
    // One bit per pipeline stage; the top bit is o_valid.
    logic [DEPTH-1:0]         r_vpipe;
    logic [COLS*ACC_W-1:0]    r_o_data;

    // Activation entering each cell and psum entering each row (row ROWS is the array bottom).
    logic signed [DATA_W-1:0] w_a_in  [ROWS][COLS];
    logic signed [ACC_W-1:0]  w_p     [ROWS+1][COLS];
    logic signed [ACC_W-1:0]  w_col_out [COLS];

    assign w_stall     = r_vpipe[DEPTH-1] && !bus.o_ready;
    assign w_o_fire    = r_vpipe[DEPTH-1] && bus.o_ready;
    assign w_w_fire    = bus.w_valid && w_w_ready;
    assign w_a_fire    = bus.a_valid && w_a_ready;
    assign w_last_beat = (r_wcnt == CNT_W'(ROWS - 1));

    // Handshake readiness and next state; a pending weight beat pre-empts activations when idle.
    always_comb begin
        w_state_nxt = r_state;
        w_w_ready   = 1'b0;
        w_a_ready   = 1'b0;
        case (r_state)
            S_EMPTY, S_LOAD: begin
                w_w_ready = 1'b1;
            end
            S_RUN: begin
                w_w_ready = (r_inflight == '0) && !w_stall;
                w_a_ready = !w_stall && !(bus.w_valid && (r_inflight == '0));
            end
            default: begin
                w_w_ready = 1'b0;
            end
        endcase
        // Nothing is accepted while reset is held, even though EMPTY would otherwise take weights.
        if (rst) begin
            w_w_ready = 1'b0;
            w_a_ready = 1'b0;
        end
        if (bus.w_valid && w_w_ready) begin
            w_state_nxt = w_last_beat ? S_RUN : S_LOAD;
        end
    end

    // State register and weight-beat counter; a RUN reload starts counting from zero again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_w_fire) begin
                r_wcnt <= w_last_beat ? '0 : r_wcnt + 1'b1;
            end
        end
    end

    // Vectors between accept and output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= '0;
        end else begin
            case ({w_a_fire, w_o_fire})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Weight load: every beat pushes rows down, so the first beat lands in the bottom row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    r_w[r][c] <= '0;
                end
            end
        end else if (w_w_fire) begin
            for (int r = ROWS - 1; r > 0; r--) begin
                r_w[r] <= r_w[r-1];
            end
            for (int c = 0; c < COLS; c++) begin
                r_w[0][c] <= $signed(bus.w_data[c*DATA_W +: DATA_W]);
            end
        end
    end

    // Valid tag pipeline and output register, both frozen under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vpipe  <= '0;
            r_o_data <= '0;
        end else if (!w_stall) begin
            r_vpipe <= {r_vpipe[DEPTH-2:0], w_a_fire};
            for (int c = 0; c < COLS; c++) begin
                r_o_data[c*ACC_W +: ACC_W] <= w_col_out[c];
            end
        end
    end

    generate
        // Input skew: row r reaches column 0 r cycles after accept. Idle slots inject zero.
        for (genvar gr = 0; gr < ROWS; gr++) begin : g_skew
            logic signed [DATA_W-1:0] w_in;
            assign w_in = w_a_fire ? $signed(bus.a_data[gr*DATA_W +: DATA_W]) : '0;
            if (gr == 0) begin : g_direct
                assign w_a_in[gr][0] = w_in;
            end else begin : g_delay
                logic signed [DATA_W-1:0] r_sk [gr];
                // Row skew shift register.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        for (int k = 0; k < gr; k++) begin
                            r_sk[k] <= '0;
                        end
                    end else if (!w_stall) begin
                        r_sk[0] <= w_in;
                        for (int k = 1; k < gr; k++) begin
                            r_sk[k] <= r_sk[k-1];
                        end
                    end
                end
                assign w_a_in[gr][0] = r_sk[gr-1];
            end
        end

        for (genvar gc = 0; gc < COLS; gc++) begin : g_ptop
            assign w_p[0][gc] = '0;
        end

        // MAC cells: activation moves right, psum moves down, weight stays put.
        for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
            for (genvar gc = 0; gc < COLS; gc++) begin : g_cell
                logic signed [2*DATA_W-1:0] w_prod;
                logic signed [ACC_W-1:0]    w_prod_ext;
                logic signed [ACC_W-1:0]    w_sum;
                logic signed [ACC_W-1:0]    r_p;

                assign w_prod     = w_a_in[gr][gc] * r_w[gr][gc];
                assign w_prod_ext = ACC_W'(w_prod);
`ifdef SYSTOLIC_SAT_EN
                logic [ACC_W:0] w_wide;
                assign w_wide = {w_p[gr][gc][ACC_W-1], w_p[gr][gc]}
                              + {w_prod_ext[ACC_W-1], w_prod_ext};
                // Clamp when the extra sign bit disagrees with the result sign.
                always_comb begin
                    w_sum = w_wide[ACC_W-1:0];
                    if (w_wide[ACC_W] != w_wide[ACC_W-1]) begin
                        w_sum = w_wide[ACC_W] ? SAT_MIN : SAT_MAX;
                    end
                end
`else
                assign w_sum = w_p[gr][gc] + w_prod_ext;
`endif
                // Partial-sum register handed to the cell below.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_p <= '0;
                    end else if (!w_stall) begin
                        r_p <= w_sum;
                    end
                end
                assign w_p[gr+1][gc] = r_p;

                if (gc < COLS - 1) begin : g_fwd
                    logic signed [DATA_W-1:0] r_a;
                    // Activation register handed to the cell on the right.
                    always_ff @(posedge clk or posedge rst) begin
                        if (rst) begin
                            r_a <= '0;
                        end else if (!w_stall) begin
                            r_a <= w_a_in[gr][gc];
                        end
                    end
                    assign w_a_in[gr][gc+1] = r_a;
                end
            end
        end

        // Output deskew: column c waits COLS-1-c cycles so the whole vector lines up.
        for (genvar gc = 0; gc < COLS; gc++) begin : g_deskew
            localparam int D = COLS - 1 - gc;
            if (D == 0) begin : g_direct
                assign w_col_out[gc] = w_p[ROWS][gc];
            end else begin : g_delay
                logic signed [ACC_W-1:0] r_dk [D];
                // Column deskew shift register.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        for (int k = 0; k < D; k++) begin
                            r_dk[k] <= '0;
                        end
                    end else if (!w_stall) begin
                        r_dk[0] <= w_p[ROWS][gc];
                        for (int k = 1; k < D; k++) begin
                            r_dk[k] <= r_dk[k-1];
                        end
                    end
                end
                assign w_col_out[gc] = r_dk[D-1];
            end
        end
    endgenerate

    assign bus.w_ready = w_w_ready;
    assign bus.a_ready = w_a_ready;
    assign bus.o_valid = r_vpipe[DEPTH-1];
    assign bus.o_data  = r_o_data;
    assign bus.busy    = (r_state == S_LOAD) || (r_inflight != '0);
endmodule

// File: tb/tb_systolic_array_ws.sv
// tb/tb_systolic_array_ws.sv - scoreboard bench for systolic_array_ws with a matrix-product reference model
`timescale 1ns/1ps
module tb_systolic_array_ws;
    localparam int DATA_W = 8;
    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int ACC_W  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    systolic_array_ws_if #(.DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS), .ACC_W(ACC_W)) bus ();

    systolic_array_ws #(.DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests  = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state: weight matrix as loaded, and expected results in order.
    logic signed [DATA_W-1:0] m_w [ROWS][COLS];
    int m_k = 0;
    logic [COLS*ACC_W-1:0] sb_q [$];
    logic [COLS*ACC_W-1:0] sb_exp;

    // Stimulus weight matrix.
    logic signed [DATA_W-1:0] tb_w [ROWS][COLS];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // result[c] = sum_r a[r]*W[r][c], accumulated top row first.
    function automatic logic [COLS*ACC_W-1:0] expect_of(input logic [ROWS*DATA_W-1:0] a);
        logic [COLS*ACC_W-1:0] res;
        longint s;
        longint p;
        longint maxv;
        longint minv;
        logic [63:0] sb;
        maxv = (longint'(1) <<< (ACC_W - 1)) - 1;
        minv = -(longint'(1) <<< (ACC_W - 1));
        res = '0;
        for (int c = 0; c < COLS; c++) begin
            s = 0;
            for (int r = 0; r < ROWS; r++) begin
                p = longint'($signed(a[r*DATA_W +: DATA_W])) * longint'(m_w[r][c]);
                s = s + p;
`ifdef SYSTOLIC_SAT_EN
                if (s > maxv) s = maxv;
                if (s < minv) s = minv;
`endif
            end
            sb = s;
            res[c*ACC_W +: ACC_W] = sb[ACC_W-1:0];
        end
        return res;
    endfunction

    // Monitor: record accepted beats/vectors and compare every delivered result.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            m_k = 0;
        end else begin
            if (bus.o_valid && bus.o_ready) begin
                if (sb_q.size() == 0) begin
                    fail_now("unexpected_output");
                end else begin
                    sb_exp = sb_q.pop_front();
                    check("o_data", bus.o_data, sb_exp);
                end
            end
            if (bus.a_valid && bus.a_ready) sb_q.push_back(expect_of(bus.a_data));
            if (bus.w_valid && bus.w_ready) begin
                for (int c = 0; c < COLS; c++) m_w[ROWS-1-m_k][c] = bus.w_data[c*DATA_W +: DATA_W];
                m_k = (m_k + 1) % ROWS;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [COLS*DATA_W-1:0] pack_row(input int r);
        logic [COLS*DATA_W-1:0] d;
        for (int c = 0; c < COLS; c++) d[c*DATA_W +: DATA_W] = tb_w[r][c];
        return d;
    endfunction

    task automatic set_identity();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) tb_w[r][c] = (r == c) ? 8'sd1 : 8'sd0;
    endtask

    task automatic set_const(input logic [7:0] v);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) tb_w[r][c] = v;
    endtask

    task automatic set_random();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) tb_w[r][c] = 8'($urandom);
    endtask

    task automatic send_w(input logic [COLS*DATA_W-1:0] d);
        bit got;
        int n;
        got = 1'b0;
        n = 0;
        bus.w_valid = 1'b1;
        bus.w_data  = d;
        do begin
            @(negedge clk);
            got = bus.w_ready;
            tick();
            n++;
        end while (!got && n < 50);
        bus.w_valid = 1'b0;
        if (!got) fail_now("w_ready_wait");
    endtask

    task automatic send_a(input logic [ROWS*DATA_W-1:0] d, output int t_acc, output int tries);
        bit got;
        got = 1'b0;
        tries = 0;
        t_acc = 0;
        bus.a_valid = 1'b1;
        bus.a_data  = d;
        do begin
            @(negedge clk);
            got = bus.a_ready;
            t_acc = cyc;
            tick();
            tries++;
        end while (!got && tries < 50);
        bus.a_valid = 1'b0;
        if (!got) fail_now("a_ready_wait");
    endtask

    // Beats k0..k1-1 of a load; beat k carries matrix row ROWS-1-k.
    task automatic load(input int k0, input int k1, input bit gaps);
        for (int k = k0; k < k1; k++) begin
            send_w(pack_row(ROWS - 1 - k));
            if (gaps) repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    // Leaves the caller at the negedge where o_valid is seen.
    task automatic wait_out();
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.o_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.o_valid) fail_now("o_valid_wait");
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) fail_now("busy_wait");
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_acc;
        int tries;
        bit done;
        logic [COLS*ACC_W-1:0] d0;
        logic [COLS*ACC_W-1:0] k_neg;
        logic [COLS*ACC_W-1:0] k_m128;

        bus.w_valid = 1'b0;
        bus.w_data  = '0;
        bus.a_valid = 1'b0;
        bus.a_data  = '0;
        bus.o_ready = 1'b1;
        k_neg = {COLS{16'hFE04}};
`ifdef SYSTOLIC_SAT_EN
        k_m128 = {COLS{16'h7FFF}};
`else
        k_m128 = '0;
`endif

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_w_ready", bus.w_ready, 0);
        check("rst_a_ready", bus.a_ready, 0);
        check("rst_o_valid", bus.o_valid, 0);
        check("rst_o_data", bus.o_data, 0);
        check("rst_busy", bus.busy, 0);
        rst = 1'b0;
        @(negedge clk);
        check("empty_w_ready", bus.w_ready, 1);
        check("empty_a_ready", bus.a_ready, 0);
        tick();

        // Identity, a=[1,2,3,4]: latency and busy
        set_identity();
        load(0, 1, 0);
        @(negedge clk);
        check("load_busy", bus.busy, 1);
        check("load_a_ready", bus.a_ready, 0);
        tick();
        load(1, ROWS, 0);
        @(negedge clk);
        check("run_a_ready", bus.a_ready, 1);
        check("run_idle_busy", bus.busy, 0);
        tick();
        send_a({8'd4, 8'd3, 8'd2, 8'd1}, t_acc, tries);
        wait_out();
        check("latency", cyc - t_acc, ROWS + COLS);
        check("identity_data", bus.o_data, {16'd4, 16'd3, 16'd2, 16'd1});
        check("busy_at_output", bus.busy, 1);
        @(negedge clk);
        check("busy_after_output", bus.busy, 0);
        check("o_valid_after_output", bus.o_valid, 0);
        tick();

        // All -1 weights, a=127
        set_const(8'hFF);
        load(0, ROWS, 0);
        send_a({ROWS{8'd127}}, t_acc, tries);
        wait_out();
        check("neg_one_data", bus.o_data, k_neg);
        tick();

        // Back-to-back identity vectors
        set_identity();
        load(0, ROWS, 1);
        for (int i = 1; i <= 3; i++) begin
            send_a({ROWS{8'(i)}}, t_acc, tries);
            check("b2b_a_ready", tries, 1);
        end
        wait_out();
        @(negedge clk);
        check("b2b_second", bus.o_valid, 1);
        @(negedge clk);
        check("b2b_third", bus.o_valid, 1);
        @(negedge clk);
        check("b2b_end", bus.o_valid, 0);
        tick();

        // Output backpressure for 3 cycles
        send_a({8'd5, 8'd6, 8'd7, 8'd8}, t_acc, tries);
        send_a({8'd9, 8'hF0, 8'd11, 8'h80}, t_acc, tries);
        bus.o_ready = 1'b0;
        wait_out();
        d0 = bus.o_data;
        for (int i = 0; i < 3; i++) begin
            check("stall_o_valid", bus.o_valid, 1);
            check("stall_o_data", bus.o_data, d0);
            check("stall_a_ready", bus.a_ready, 0);
            if (i < 2) @(negedge clk);
        end
        tick();
        bus.o_ready = 1'b1;
        @(negedge clk);
        check("release_first", bus.o_valid, 1);
        @(negedge clk);
        check("release_second", bus.o_valid, 1);
        @(negedge clk);
        check("release_end", bus.o_valid, 0);
        tick();

        // All -128
        set_const(8'h80);
        load(0, ROWS, 0);
        send_a({ROWS{8'h80}}, t_acc, tries);
        wait_out();
        check("m128_data", bus.o_data, k_m128);
        tick();

        // Weight beat pre-empts an activation when idle
        set_random();
        bus.w_valid = 1'b1;
        bus.w_data  = pack_row(ROWS - 1);
        bus.a_valid = 1'b1;
        bus.a_data  = 32'($urandom);
        @(negedge clk);
        check("preempt_a_ready", bus.a_ready, 0);
        check("preempt_w_ready", bus.w_ready, 1);
        tick();
        bus.w_valid = 1'b0;
        bus.a_valid = 1'b0;
        @(negedge clk);
        check("preempt_busy", bus.busy, 1);
        tick();
        load(1, ROWS, 1);

        // Randomised streams with random backpressure and reloads
        for (int it = 0; it < 4; it++) begin
            if (it != 0) begin
                set_random();
                load(0, ROWS, 1);
            end
            done = 1'b0;
            fork
                begin
                    int ta;
                    int tr;
                    for (int v = 0; v < 40; v++) begin
                        send_a(32'($urandom), ta, tr);
                        repeat ($urandom_range(0, 2)) tick();
                    end
                    done = 1'b1;
                end
                begin
                    while (!done) begin
                        bus.o_ready = ($urandom_range(0, 3) != 0);
                        tick();
                    end
                    bus.o_ready = 1'b1;
                end
            join
            wait_idle();
            check("drain_empty", sb_q.size(), 0);
        end

        // Reset mid-stream
        bus.o_ready = 1'b0;
        send_a(32'($urandom), t_acc, tries);
        send_a(32'($urandom), t_acc, tries);
        wait_out();
        tick();
        rst = 1'b1;
        #1;
        check("mrst_o_valid", bus.o_valid, 0);
        check("mrst_o_data", bus.o_data, 0);
        check("mrst_busy", bus.busy, 0);
        check("mrst_a_ready", bus.a_ready, 0);
        check("mrst_w_ready", bus.w_ready, 0);
        tick();
        rst = 1'b0;
        bus.o_ready = 1'b1;
        bus.a_valid = 1'b1;
        bus.a_data  = 32'($urandom);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_a_ready", bus.a_ready, 0);
            check("post_rst_o_valid", bus.o_valid, 0);
        end
        tick();
        bus.a_valid = 1'b0;

        // Reset mid-load
        set_random();
        load(0, 2, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_random();
        load(0, ROWS - 1, 0);
        @(negedge clk);
        check("partial_a_ready", bus.a_ready, 0);
        check("partial_busy", bus.busy, 1);
        tick();
        load(ROWS - 1, ROWS, 0);
        @(negedge clk);
        check("reloaded_a_ready", bus.a_ready, 1);
        tick();
        send_a(32'($urandom), t_acc, tries);
        send_a(32'($urandom), t_acc, tries);
        wait_idle();
        check("final_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
